// File: rtl/axi_line_master_if.sv
// axi_line_master_if: AXI4 master-side bus bundle between the line master and its slave
interface axi_line_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ID_WIDTH-1:0]   awid, bid, arid, rid;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0]            awlen, arlen;
  logic [2:0]            awsize, arsize, awprot, arprot;
  logic [1:0]            awburst, arburst, bresp, rresp;
  logic [3:0]            awcache, arcache;
  logic                  awlock, arlock;
  logic                  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready, rlast;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [STRB_WIDTH-1:0] wstrb;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_line_master.sv
// axi_line_master: single-outstanding AXI4 master moving whole cache lines as fixed INCR bursts
module axi_line_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LINE_WORDS = 8,
  parameter int RD_ID      = 0,
  parameter int WR_ID      = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int LINE_BITS  = LINE_WORDS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LINE_BITS-1:0]  resp_rdata,
  output logic                  resp_err,
  axi_line_master_if.master     m_axi
);
  localparam int LB = $clog2(LINE_WORDS);
  localparam int CW = LB + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(LINE_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(LINE_WORDS * STRB_WIDTH - 1);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;
  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_beat, w_beat_n;
  logic                  r_err, w_err_n;
  logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_wlast, r_bready;
  logic                  r_resp_valid, r_resp_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_BITS-1:0]  r_wbuf, r_rline;
  logic [DATA_WIDTH-1:0] r_wdata;

  assign req_ready       = (r_state == S_IDLE) && !rst;
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;
  assign resp_rdata      = r_rline;
  assign m_axi.awid      = ID_WIDTH'(WR_ID);
  assign m_axi.awaddr    = r_addr;
  assign m_axi.awlen     = 8'(LINE_WORDS - 1);
  assign m_axi.awsize    = 3'($clog2(STRB_WIDTH));
  assign m_axi.awburst   = 2'b01;
  assign m_axi.awlock    = 1'b0;
  assign m_axi.awcache   = 4'b0011;
  assign m_axi.awprot    = 3'b000;
  assign m_axi.awvalid   = r_awvalid;
  assign m_axi.wdata     = r_wdata;
  assign m_axi.wstrb     = '1;
  assign m_axi.wlast     = r_wlast;
  assign m_axi.wvalid    = r_wvalid;
  assign m_axi.bready    = r_bready;
  assign m_axi.arid      = ID_WIDTH'(RD_ID);
  assign m_axi.araddr    = r_addr;
  assign m_axi.arlen     = 8'(LINE_WORDS - 1);
  assign m_axi.arsize    = 3'($clog2(STRB_WIDTH));
  assign m_axi.arburst   = 2'b01;
  assign m_axi.arlock    = 1'b0;
  assign m_axi.arcache   = 4'b0011;
  assign m_axi.arprot    = 3'b000;
  assign m_axi.arvalid   = r_arvalid;
  assign m_axi.rready    = r_rready;

  // next state, beat counter and sticky error; beat saturates at FULL so surplus R beats are dropped
  always_comb begin
    w_state_n = r_state;
    w_beat_n  = r_beat;
    w_err_n   = r_err;
    case (r_state)
      S_IDLE: if (req_valid && req_ready) begin
        w_state_n = req_write ? S_AW : S_AR;
        w_beat_n  = '0;
        w_err_n   = 1'b0;
      end
      S_AR:   if (m_axi.arready) w_state_n = S_R;
      S_R:    if (m_axi.rvalid) begin
        w_beat_n  = (r_beat == FULL) ? r_beat : r_beat + CW'(1);
        w_err_n   = r_err | (m_axi.rresp != 2'b00) | (m_axi.rlast ? (r_beat != LAST) : (r_beat == LAST));
        w_state_n = m_axi.rlast ? S_RESP : S_R;
      end
      S_AW:   if (m_axi.awready) w_state_n = S_W;
      S_W:    if (m_axi.wready) begin
        w_beat_n  = r_beat + CW'(1);
        w_state_n = (r_beat == LAST) ? S_B : S_W;
      end
      S_B:    if (m_axi.bvalid) begin
        w_err_n   = r_err | (m_axi.bresp != 2'b00);
        w_state_n = S_RESP;
      end
      S_RESP: if (resp_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // state register plus handshake outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_beat       <= w_beat_n;
      r_err        <= w_err_n;
      r_arvalid    <= w_state_n == S_AR;
      r_rready     <= w_state_n == S_R;
      r_awvalid    <= w_state_n == S_AW;
      r_wvalid     <= w_state_n == S_W;
      r_wlast      <= (w_state_n == S_W) && (w_beat_n == LAST);
      r_bready     <= w_state_n == S_B;
      r_resp_valid <= w_state_n == S_RESP;
      r_resp_err   <= (w_state_n == S_RESP) && w_err_n;
    end
  end

  // line buffers and W payload; unreset because they are only read once qualified by the FSM
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_valid) begin
      r_addr <= req_addr & MASK;
      r_wbuf <= req_wdata;
    end
    if (r_state == S_R && m_axi.rvalid && !r_beat[LB])
      r_rline[r_beat[LB-1:0] * DATA_WIDTH +: DATA_WIDTH] <= m_axi.rdata;
    r_wdata <= r_wbuf[w_beat_n[LB-1:0] * DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: scoreboard bench with a stalling AXI RAM slave model and protocol monitor
module tb_axi_line_master;
  localparam int DW = 32, AW = 32, IW = 8, LW = 8, LBITS = LW * DW;
  typedef struct packed {logic [LBITS-1:0] line; logic err;} exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LBITS-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [LBITS-1:0] resp_rdata;
  always #5 clk = ~clk;

  axi_line_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();
  axi_line_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_WORDS(LW), .RD_ID(0), .WR_ID(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .m_axi(bus.master));

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [1024];
  logic [LBITS-1:0] last_refill = '0, obs_line;
  logic obs_err, obs_to;

  // slave model state and fault-injection knobs
  logic [DW-1:0] mem [1024];
  bit mem_ok = 0;
  int stall = 0, err_beat = -1, rd_beats = LW;
  int rd_ptr = 0, rd_idx = 0, rd_left = 0, wr_ptr = 0, wr_idx = 0, w_total = 0, b_pend = 0, wlast_bad = 0;

  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
      mem_ok = 1;
    end
    if (rst) begin
      bus.arready <= 0; bus.awready <= 0; bus.wready <= 0; bus.rvalid <= 0; bus.bvalid <= 0;
      bus.rlast <= 0; bus.rresp <= 0; bus.bresp <= 0; bus.rdata <= 0; bus.rid <= 0; bus.bid <= 0;
      rd_left = 0; b_pend = 0;
    end else begin
      bus.arready <= stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.awready <= stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  <= stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.arvalid && bus.arready) begin
        rd_ptr = int'(bus.araddr[11:2]); rd_idx = 0; rd_left = rd_beats;
      end
      if (bus.rvalid && bus.rready) begin
        rd_idx++; rd_left--;
      end
      if (!bus.rvalid || bus.rready) begin
        if (rd_left > 0 && (stall == 0 || $urandom_range(0, 2) != 0)) begin
          bus.rvalid <= 1'b1;
          bus.rdata  <= mem[(rd_ptr + rd_idx) % 1024];
          bus.rlast  <= rd_left == 1;
          bus.rresp  <= rd_idx == err_beat ? 2'b10 : 2'b00;
        end else bus.rvalid <= 1'b0;
      end
      if (bus.awvalid && bus.awready) begin
        wr_ptr = int'(bus.awaddr[11:2]); wr_idx = 0;
      end
      if (bus.wvalid && bus.wready) begin
        mem[(wr_ptr + wr_idx) % 1024] = bus.wdata;
        if (bus.wlast !== (wr_idx == LW - 1)) wlast_bad++;
        if (bus.wlast) b_pend = 1;
        wr_idx++; w_total++;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (b_pend != 0 && (!bus.bvalid || bus.bready) && (stall == 0 || $urandom_range(0, 2) != 0)) begin
        bus.bvalid <= 1'b1; bus.bresp <= 2'b00; b_pend = 0;
      end
    end
  end

  // protocol monitor: a valid must hold with a stable payload until its ready
  int viol = 0;
  logic p_rst = 1, p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0, p_rv = 0, p_rr = 0;
  logic [AW-1:0] p_araddr = '0, p_awaddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [LBITS-1:0] p_rdata = '0;
  always @(posedge clk) begin
    if (!p_rst) begin
      if (p_arv && !p_arr && (!bus.arvalid || bus.araddr !== p_araddr)) viol++;
      if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr !== p_awaddr)) viol++;
      if (p_wv && !p_wr && (!bus.wvalid || bus.wdata !== p_wdata || bus.wlast !== p_wl)) viol++;
      if (p_rv && !p_rr && (!resp_valid || resp_rdata !== p_rdata)) viol++;
    end
    p_rst = rst; p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
    p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
    p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata; p_wl = bus.wlast;
    p_rv = resp_valid; p_rr = resp_ready; p_rdata = resp_rdata;
  end

  function automatic void model(input logic w, input logic [AW-1:0] a, input logic [LBITS-1:0] d, input logic e, input int nb);
    exp_t x;
    int base = int'(a[11:5]) * LW;
    x.line = last_refill;
    x.err  = e;
    for (int k = 0; k < LW; k++) begin
      if (w) ref_mem[base + k] = d[k*DW +: DW];
      else if (k < nb) x.line[k*DW +: DW] = ref_mem[base + k];
    end
    if (!w) last_refill = x.line;
    exp_q.push_back(x);
  endfunction

  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [LBITS-1:0] d);
    int n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    if (!req_ready) obs_to = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic get_resp();
    int n = 0;
    while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
    if (!resp_valid) obs_to = 1;
    else begin
      obs_line = resp_rdata; obs_err = resp_err; resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
    end
  endtask

  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [LBITS-1:0] d, input logic e, input int nb);
    obs_to = 0;
    model(w, a, d, e, nb);
    send_req(w, a, d);
    get_resp();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready, resp_valid, resp_err, req_ready} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000000", {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready, resp_valid, resp_err, req_ready});
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_refill();
    exp_t x;
    obs_to = 0;
    model(0, 32'h47, '0, 0, LW);
    send_req(0, 32'h47, '0);
    checks++;
    if (bus.arvalid !== 1 || bus.araddr !== 32'h40 || bus.arlen !== 8'd7 || bus.arsize !== 3'd2 || bus.arburst !== 2'b01 || bus.arid !== 8'd0 || bus.arcache !== 4'b0011) begin
      errors++; $display("FAIL refill_ar got v=%b addr=%h len=%0d size=%0d burst=%b id=%0d cache=%b exp 1 40 7 2 01 0 0011",
        bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid, bus.arcache);
    end
    get_resp();
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== x.err) begin
      errors++; $display("FAIL refill_line got to=%b %h err=%b exp %h err=%b", obs_to, obs_line, obs_err, x.line, x.err);
    end
    checks++;
    if (obs_line[31:0] !== 32'h1010 || obs_line[255:224] !== 32'h1017) begin
      errors++; $display("FAIL refill_words got w0=%h w7=%h exp 1010 1017", obs_line[31:0], obs_line[255:224]);
    end
  endtask

  task automatic test_writeback();
    exp_t x;
    logic [LBITS-1:0] d;
    for (int k = 0; k < LW; k++) d[k*DW +: DW] = 32'hA0 + k;
    obs_to = 0;
    model(1, 32'h80, d, 0, LW);
    send_req(1, 32'h80, d);
    checks++;
    if (bus.awvalid !== 1 || bus.awaddr !== 32'h80 || bus.awlen !== 8'd7 || bus.awsize !== 3'd2 || bus.awburst !== 2'b01 || bus.awid !== 8'd1) begin
      errors++; $display("FAIL wb_aw got v=%b addr=%h len=%0d size=%0d burst=%b id=%0d exp 1 80 7 2 01 1",
        bus.awvalid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid);
    end
    get_resp();
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== x.err) begin
      errors++; $display("FAIL wb_resp got to=%b %h err=%b exp %h err=%b", obs_to, obs_line, obs_err, x.line, x.err);
    end
    checks++;
    if (wlast_bad != 0) begin errors++; $display("FAIL wb_wlast got %0d bad beats exp 0", wlast_bad); end
    run_txn(0, 32'h80, '0, 0, LW);
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== d || obs_err !== 1'b0) begin
      errors++; $display("FAIL wb_readback got to=%b %h err=%b exp %h err=0", obs_to, obs_line, obs_err, d);
    end
  endtask

  task automatic test_backpressure();
    exp_t x;
    logic [LBITS-1:0] snap;
    logic stable = 1;
    int n = 0;
    obs_to = 0;
    model(0, 32'h200, '0, 0, LW);
    send_req(0, 32'h200, '0);
    while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
    snap = resp_rdata;
    model(0, 32'h240, '0, 0, LW);
    req_valid = 1; req_write = 0; req_addr = 32'h240;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== snap || req_ready) stable = 0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_hold got stable=%b exp 1", stable); end
    x = exp_q.pop_front();
    checks++;
    if (snap !== x.line || resp_err !== x.err) begin
      errors++; $display("FAIL bp_line got %h err=%b exp %h err=%b", snap, resp_err, x.line, x.err);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++;
    if (resp_valid !== 0 || req_ready !== 1 || bus.arvalid !== 0) begin
      errors++; $display("FAIL bp_release got resp_valid=%b req_ready=%b arvalid=%b exp 0 1 0", resp_valid, req_ready, bus.arvalid);
    end
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (bus.arvalid !== 1 || bus.araddr !== 32'h240) begin
      errors++; $display("FAIL bp_next_accept got arvalid=%b araddr=%h exp 1 240", bus.arvalid, bus.araddr);
    end
    obs_to = 0;
    get_resp();
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== x.err) begin
      errors++; $display("FAIL bp_second got to=%b %h err=%b exp %h err=%b", obs_to, obs_line, obs_err, x.line, x.err);
    end
  endtask

  task automatic test_errors();
    exp_t x;
    err_beat = 3;
    run_txn(0, 32'h300, '0, 1, LW);
    err_beat = -1;
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== 1'b1) begin
      errors++; $display("FAIL rresp_err got to=%b %h err=%b exp %h err=1", obs_to, obs_line, obs_err, x.line);
    end
    checks++;
    if (rd_idx != LW) begin errors++; $display("FAIL rresp_beats got %0d exp %0d", rd_idx, LW); end
    rd_beats = 6;
    run_txn(0, 32'h340, '0, 1, 6);
    rd_beats = LW;
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== 1'b1) begin
      errors++; $display("FAIL short_burst got to=%b %h err=%b exp %h err=1", obs_to, obs_line, obs_err, x.line);
    end
    run_txn(0, 32'h380, '0, 0, LW);
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== 1'b0) begin
      errors++; $display("FAIL after_err got to=%b %h err=%b exp %h err=0", obs_to, obs_line, obs_err, x.line);
    end
  endtask

  task automatic test_stall();
    exp_t x;
    logic [LBITS-1:0] d;
    logic w;
    logic [AW-1:0] a;
    stall = 1;
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 4095));
      for (int k = 0; k < LW; k++) d[k*DW +: DW] = $urandom();
      run_txn(w, a, d, 0, LW);
      x = exp_q.pop_front();
      checks++;
      if (obs_to || obs_line !== x.line || obs_err !== x.err) begin
        errors++; $display("FAIL stall_txn%0d w=%b a=%h got to=%b %h err=%b exp %h err=%b", i, w, a, obs_to, obs_line, obs_err, x.line, x.err);
      end
    end
    stall = 0;
    checks++;
    if (viol != 0 || wlast_bad != 0) begin
      errors++; $display("FAIL stall_protocol got viol=%0d wlast_bad=%0d exp 0 0", viol, wlast_bad);
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    logic [LBITS-1:0] d;
    int start, n = 0;
    for (int k = 0; k < LW; k++) d[k*DW +: DW] = 32'hC0DE0000 + k;
    obs_to = 0;
    start = w_total;
    send_req(1, 32'hC00, d);
    while (w_total - start < 4 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (w_total - start != 4) begin errors++; $display("FAIL rstmid_beats got %0d exp 4", w_total - start); end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, resp_valid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_valids got %b exp 000000", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, resp_valid});
    end
    rst = 0;
    @(negedge clk);
    run_txn(0, 32'h100, '0, 0, LW);
    x = exp_q.pop_front();
    checks++;
    if (obs_to || obs_line !== x.line || obs_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_refill got to=%b %h err=%b exp %h err=0", obs_to, obs_line, obs_err, x.line);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h1000 + i;
    test_reset();
    test_refill();
    test_writeback();
    test_backpressure();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_line_master.md
# axi_line_master

Single-outstanding AXI4 master that turns cache-line refill and writeback requests from the L1 miss handler into fixed-length INCR bursts. It sits directly upstream of the AXI4 RAM slave and drives its full s_axi port set. It buffers one full line, so the client hands over or receives the whole line in one handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; STRB_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 32, AXI and request address width.
- ID_WIDTH, 8, AXI ID width.
- LINE_WORDS, 8, beats per line, power of two, 2..256; LINE_BITS = LINE_WORDS*DATA_WIDTH.
- RD_ID, 0, ID driven on AR.
- WR_ID, 1, ID driven on AW.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  high only in IDLE and not rst.
- req_write  in  1  1 = writeback, 0 = refill.
- req_addr  in  ADDR_WIDTH  line address; low log2(LINE_WORDS*STRB_WIDTH) bits ignored and forced to 0.
- req_wdata  in  LINE_BITS  writeback line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- resp_valid  out  1  transaction complete.
- resp_ready  in  1  client accepts the response.
- resp_rdata  out  LINE_BITS  refill line, same packing; holds the last refill for writes.
- resp_err  out  1  any non-OKAY resp or burst-length violation in this transaction.
- m_axi_awid/awaddr/awlen/awsize/awburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload.
- m_axi_awvalid out 1, m_axi_awready in 1  AW handshake.
- m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/STRB_WIDTH/1  W payload.
- m_axi_wvalid out 1, m_axi_wready in 1  W handshake.
- m_axi_bid/bresp  in  ID_WIDTH/2; m_axi_bvalid in 1, m_axi_bready out 1  B channel.
- m_axi_arid/araddr/arlen/arsize/arburst  out  as AW  AR payload.
- m_axi_arvalid out 1, m_axi_arready in 1  AR handshake.
- m_axi_rid/rdata/rresp/rlast  in  ID_WIDTH/DATA_WIDTH/2/1; m_axi_rvalid in 1, m_axi_rready out 1  R channel.
- m_axi_awlock/arlock out 1 = 0, awcache/arcache out 4 = 4'b0011, awprot/arprot out 3 = 0  constant.

## Operation
- States: IDLE, AR, R, AW, W, B, RESP. All valid/ready outputs and payloads are registered, except req_ready = (state==IDLE) && !rst.
- Burst constants: len = LINE_WORDS-1, size = log2(STRB_WIDTH), burst = 2'b01 (INCR), wstrb all ones.
- IDLE: on req_valid && req_ready, latch the aligned address, req_wdata and the write flag, clear the error flag and beat counter, and go to AW (write) or AR (read).
- AR: arvalid=1 until arready, then go to R. R: rready=1. Each beat stores rdata at word[beat] and increments beat. rresp!=0 sets err. On the beat with rlast, go to RESP. If rlast arrives with beat != LINE_WORDS-1, set err and still finish. If beat LINE_WORDS-1 arrives without rlast, set err and keep accepting until rlast, discarding extra beats.
- AW: awvalid=1 until awready, then go to W. W: wvalid=1, wdata = word[beat], wlast = (beat==LINE_WORDS-1). Advance beat on each wready. After the last handshake, go to B.
- B: bready=1. On bvalid, err |= (bresp!=0), then go to RESP. bid and rid are not checked.
- RESP: resp_valid=1 and resp_err=err until resp_ready, then go to IDLE.
- Beat counter width is log2(LINE_WORDS)+1; no wrap inside a line.

## Timing
- Reset values: all m_axi_*valid, rready, bready, resp_valid, resp_err and wlast are 0; state is IDLE. Line buffer and payload registers are don't-care.
- Request accepted in cycle t: arvalid or awvalid is first high in t+1.
- R beats are accepted every cycle while rvalid is high, with zero bubbles. W beats are issued back-to-back while wready is high.
- resp_valid is first high one cycle after the rlast or bvalid handshake. req_ready is high one cycle after the resp handshake.
- Simultaneous resp_valid and resp_ready, with req_valid held: the new request is accepted no earlier than the next cycle.
- rst mid-transaction: abandons it; all valids are 0 the next cycle. Slave consistency is the integrator's responsibility, and the slave is reset together with this block.
- AW is never issued concurrently with W; at most one transaction is outstanding.

## Test plan
- Refill: RAM preloaded word i = 0x1000+i; read req_addr 0x47 -> araddr 0x40, arlen 7, arsize 2; resp_rdata words = 0x1010..0x1017; resp_err 0.
- Writeback: req_addr 0x80, words 0xA0..0xA7, then a refill of 0x80 -> identical line returned; wlast high only on beat 7.
- Back-pressure: hold resp_ready low 5 cycles -> resp_valid and data stable; req_ready stays 0 until the handshake; the next request is accepted the cycle after.
- Error: slave model returns rresp=2'b10 on beat 3 -> all 8 beats still consumed, resp_err=1. Short burst (rlast on beat 5) -> resp_err=1, no hang.
- Stalls: randomly toggle arready, wready, rvalid and bvalid over 200 mixed transactions -> data matches the scoreboard and no protocol violation occurs (valid never drops before ready).
- Reset in W after beat 3 -> all valids 0 next cycle; after reset, a fresh refill completes correctly.
